// File: rtl/arb_mux_if.sv
// Handshake bundle for arb_mux: N request channels in, one registered word out.
// The master drives requests and the consumer ready; the slave is the mux itself.
interface arb_mux_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 4,
   parameter int unsigned SELW  = $clog2(N)
) ();
   logic [N-1:0]       in_valid;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_ready;
   logic               rr_en;
   logic [SELW-1:0]    sel;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [SELW-1:0]    out_src;
   logic               out_ready;

   modport master (
      output in_valid, in_data, rr_en, sel, out_ready,
      input  in_ready, out_valid, out_data, out_src
   );

   modport slave (
      input  in_valid, in_data, rr_en, sel, out_ready,
      output in_ready, out_valid, out_data, out_src
   );
endinterface

// File: rtl/arb_mux.sv
// N-input registered mux with valid/ready on every side; selects either by a
// fixed index or by round-robin across requesting channels. Holds one word.
module arb_mux #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 4
) (
   input logic      clk,
   input logic      rst,
   arb_mux_if.slave bus
);
   localparam int unsigned SELW = $clog2(N);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_src_q, out_src_d;
   logic [SELW-1:0]  ptr_q, ptr_d;

   logic             load;
   logic             granted;
   logic             xfer;
   logic [SELW-1:0]  grant;
   logic [SELW-1:0]  idx;
   logic [WIDTH-1:0] ch_data [N];

   for (genvar g = 0; g < N; g++) begin : g_unpack
      assign ch_data[g] = bus.in_data[g*WIDTH +: WIDTH];
   end

   // Register can take a word when empty or when it drains this cycle.
   assign load = (state_q == EMPTY) || bus.out_ready;

   // Grant selection; an out-of-range sel matches no channel, so it never aliases.
   always_comb begin
      granted = 1'b0;
      grant   = '0;
      idx     = '0;
      if (bus.rr_en) begin
         for (int unsigned k = 1; k <= N; k++) begin
            idx = SELW'((32'(ptr_q) + k) % N);
            if (!granted && bus.in_valid[idx]) begin
               granted = 1'b1;
               grant   = idx;
            end
         end
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            if (bus.sel == SELW'(i) && bus.in_valid[SELW'(i)]) begin
               granted = 1'b1;
               grant   = SELW'(i);
            end
         end
      end
   end

   assign xfer         = load && granted && !rst;
   assign bus.in_ready = xfer ? (N'(1) << grant) : '0;

   // Next state and datapath updates.
   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_src_d  = out_src_q;
      ptr_d      = ptr_q;
      case (state_q)
         EMPTY:   if (xfer) state_d = FULL;
         FULL:    if (bus.out_ready && !xfer) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
      if (xfer) begin
         out_data_d = ch_data[grant];
         out_src_d  = grant;
         if (bus.rr_en) ptr_d = grant;
      end
   end

   // ptr resets to the last channel so channel 0 is searched first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         out_data_q <= '0;
         out_src_q  <= '0;
         ptr_q      <= SELW'(N - 1);
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         out_src_q  <= out_src_d;
         ptr_q      <= ptr_d;
      end
   end

   assign bus.out_valid = (state_q == FULL);
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: fixed and round-robin selection, back-pressure,
// out-of-range select, a non-power-of-two channel count and asynchronous reset.
module tb_arb_mux;
   logic clk = 1'b0;
   logic rst;

   int n_assert = 0;
   int n_fail   = 0;

   arb_mux_if #(.WIDTH(32), .N(4)) bus ();
   arb_mux_if #(.WIDTH(32), .N(3)) b3 ();

   arb_mux #(.WIDTH(32), .N(4)) u_dut (.clk(clk), .rst(rst), .bus(bus));
   arb_mux #(.WIDTH(32), .N(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 4'b1111;
      bus.in_data   = {32'd4, 32'd3, 32'd2, 32'd1};
      bus.rr_en     = 1'b1;
      bus.sel       = 2'd0;
      bus.out_ready = 1'b1;
      b3.in_valid   = 3'b000;
      b3.in_data    = {32'hC, 32'hB, 32'hA};
      b3.rr_en      = 1'b0;
      b3.sel        = 2'd0;
      b3.out_ready  = 1'b1;
      #1;
      check("rst_valid", 64'(bus.out_valid), 64'd0);
      check("rst_data", 64'(bus.out_data), 64'd0);
      check("rst_src", 64'(bus.out_src), 64'd0);
      check("rst_ready", 64'(bus.in_ready), 64'd0);
      tick();
      tick();
      check("rst_hold_ready", 64'(bus.in_ready), 64'd0);

      bus.in_valid = 4'b0000;
      bus.rr_en    = 1'b0;
      rst          = 1'b0;
      tick();
      check("idle_valid", 64'(bus.out_valid), 64'd0);

      // Fixed select, stepping sel 0..3
      bus.in_valid = 4'b1111;
      for (int s = 0; s < 4; s++) begin
         bus.sel = 2'(s);
         #1;
         check("fix_ready", 64'(bus.in_ready), 64'(1) << s);
         tick();
         check("fix_valid", 64'(bus.out_valid), 64'd1);
         check("fix_data", 64'(bus.out_data), 64'(s + 1));
         check("fix_src", 64'(bus.out_src), 64'(s));
      end

      // Round-robin, all channels requesting
      bus.rr_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         check("rr_ready", 64'(bus.in_ready), 64'(1) << (k % 4));
         tick();
         check("rr_valid", 64'(bus.out_valid), 64'd1);
         check("rr_src", 64'(bus.out_src), 64'(k % 4));
         check("rr_data", 64'(bus.out_data), 64'((k % 4) + 1));
      end

      // Round-robin with only ch1 and ch3 requesting
      bus.in_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("rr13_ready", 64'(bus.in_ready), (k % 2 == 0) ? 64'h2 : 64'h8);
         tick();
         check("rr13_src", 64'(bus.out_src), (k % 2 == 0) ? 64'd1 : 64'd3);
      end

      // Back-pressure on a held word
      bus.rr_en             = 1'b0;
      bus.sel               = 2'd2;
      bus.in_valid          = 4'b0100;
      bus.in_data[64 +: 32] = 32'hDEADBEEF;
      tick();
      check("bp_load_data", 64'(bus.out_data), 64'hDEADBEEF);
      check("bp_load_src", 64'(bus.out_src), 64'd2);
      bus.out_ready         = 1'b0;
      bus.in_data[64 +: 32] = 32'h12345678;
      #1;
      for (int k = 0; k < 5; k++) begin
         check("bp_ready", 64'(bus.in_ready), 64'd0);
         tick();
         check("bp_valid", 64'(bus.out_valid), 64'd1);
         check("bp_data", 64'(bus.out_data), 64'hDEADBEEF);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(bus.in_ready), 64'h4);
      tick();
      check("bp_next_valid", 64'(bus.out_valid), 64'd1);
      check("bp_next_data", 64'(bus.out_data), 64'h12345678);

      // Fixed select on a channel that is not requesting
      bus.in_valid = 4'b1011;
      #1;
      check("nogrant_ready", 64'(bus.in_ready), 64'd0);
      tick();
      check("nogrant_valid", 64'(bus.out_valid), 64'd0);
      check("nogrant_data", 64'(bus.out_data), 64'h12345678);
      check("nogrant_src", 64'(bus.out_src), 64'd2);
      tick();
      check("nogrant_valid2", 64'(bus.out_valid), 64'd0);

      // Reset while full with ptr=1
      bus.in_data  = {32'd4, 32'd3, 32'd2, 32'd1};
      bus.rr_en    = 1'b1;
      bus.in_valid = 4'b0010;
      tick();
      check("pre_rst_src", 64'(bus.out_src), 64'd1);
      bus.out_ready = 1'b0;
      bus.in_valid  = 4'b1111;
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", 64'(bus.out_valid), 64'd0);
      check("arst_data", 64'(bus.out_data), 64'd0);
      check("arst_src", 64'(bus.out_src), 64'd0);
      check("arst_ready", 64'(bus.in_ready), 64'd0);
      #2;
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check("post_rst_ready", 64'(bus.in_ready), 64'h1);
      tick();
      check("post_rst_src", 64'(bus.out_src), 64'd0);
      check("post_rst_data", 64'(bus.out_data), 64'd1);
      tick();
      check("post_rst_src2", 64'(bus.out_src), 64'd1);

      // Three channels: out-of-range select, then wrap-around in round-robin
      b3.in_valid = 3'b111;
      b3.sel      = 2'd3;
      #1;
      check("n3_sel3_ready", 64'(b3.in_ready), 64'd0);
      tick();
      check("n3_sel3_valid", 64'(b3.out_valid), 64'd0);
      b3.sel = 2'd2;
      #1;
      check("n3_sel2_ready", 64'(b3.in_ready), 64'h4);
      tick();
      check("n3_sel2_valid", 64'(b3.out_valid), 64'd1);
      check("n3_sel2_data", 64'(b3.out_data), 64'hC);
      b3.rr_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("n3_rr_src", 64'(b3.out_src), 64'(k % 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- Parametrised N-input, WIDTH-bit multiplexer with a registered output and valid/ready handshakes on every input and on the output.
- Operates in one of two runtime modes: fixed-select, driven by `sel` as a plain mux, or round-robin arbitration across requesting channels.
- Intended for the pipelined datapath: writeback/forwarding source selection and sharing the memory port between fetch and load/store.
- Holds one word. Back-pressure from the consumer stalls the producers.

Parameters:
- WIDTH, 32, data width of each channel and of the output.
- N, 4, number of input channels (2..16, any integer).
- SELW, $clog2(N), width of `sel`/`out_src`. Derived value; callers do not override it.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  N  per-channel request; bit i belongs to channel i.
- in_data  in  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
- in_ready  out  N  per-channel accept, one-hot or zero; combinational.
- rr_en  in  1  0 = fixed-select mode, 1 = round-robin mode.
- sel  in  SELW  channel index used in fixed-select mode.
- out_valid  out  1  output register holds a word.
- out_data  out  WIDTH  registered selected data.
- out_src  out  SELW  index of the channel that produced out_data.
- out_ready  in  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_src=0, round-robin pointer ptr=N-1 (so channel 0 has first priority). All in_ready=0 while rst=1.
- State machine (2 states):
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Load enable: load = !out_valid | out_ready. The register can accept when it is empty or is being drained in the same cycle.
- Grant, fixed-select mode (rr_en=0):
  - grant = sel when sel<N and in_valid[sel]=1; otherwise no grant.
  - sel>=N always means no grant. It never aliases to another channel.
- Grant, round-robin mode (rr_en=1):
  - Search starts at (ptr+1) mod N and scans upward with wrap-around.
  - The first i with in_valid[i]=1 wins.
- Handshake:
  - in_ready[i] = load & granted & (grant==i).
  - A transfer on channel i happens when in_valid[i] & in_ready[i].
  - A channel with valid=0 never gets ready=1.
- On a transfer: out_data<=in_data[i], out_src<=i, out_valid<=1.
  - In round-robin mode, ptr<=i as well.
  - ptr never moves in fixed-select mode or on cycles with no transfer.
- Drain with no new transfer (out_valid & out_ready): out_valid<=0. out_data and out_src keep their last values.
- Stall (out_valid & !out_ready):
  - out_data and out_src stay stable.
  - in_ready is all zeros.
- Simultaneous drain and load: full throughput, one word per cycle, and no bubble.
- Latency: exactly 1 cycle from input transfer to out_valid.
- Mode switch: rr_en is sampled each cycle. Switching from fixed to rr resumes from the current ptr.
- Reset mid-operation: any held word is discarded, and ptr returns to N-1.
- Fairness: in rr mode with all channels requesting continuously and out_ready=1, the grant sequence is 0,1,...,N-1,0,...

Test Plan:
1. Fixed mode, N=4, in_data={4,3,2,1} (ch3..ch0), all valid, out_ready=1. Stepping sel=0,1,2,3 gives out_data=1,2,3,4 with out_src=0..3, each one cycle after the corresponding sel.
2. RR mode, all 4 valid, out_ready=1 for 8 cycles: out_src sequence 0,1,2,3,0,1,2,3, with out_valid=1 every cycle after the first.
3. RR mode, only ch1 and ch3 valid: grants alternate 1,3,1,3. Channels 0 and 2 never see in_ready.
4. Back-pressure: load ch2=0xDEADBEEF, then hold out_ready=0 for 5 cycles. out_data stays 0xDEADBEEF and in_ready=0000 throughout. Raising out_ready drains the word, and the next word loads in the same cycle.
5. Fixed mode with sel=2 and in_valid[2]=0 while others are valid: no grant, and out_valid falls to 0 after the drain. With N=3 and sel=3: no grant.
6. Assert rst while FULL with ptr=1: out_valid=0, out_data=0, out_src=0 immediately (asynchronous). After release, in RR mode with all valid, the first grant is ch0.
